// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider and sequencer for DIV/DIVU; stalls the pipe while running.
// Optional `DIV_ZERO_FAST_EN: division by zero skips the RUN phase and completes right after PREP.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancel,
    output logic             stall_div,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, rem_step;
    logic [WIDTH-1:0] quo_step, quo_fix, rem_fix;
    logic             ge;

    // Magnitudes; 0x8000.. negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (sgn_q && op_a_q[WIDTH-1]) ? (~op_a_q + 1'b1) : op_a_q;
        b_mag = (sgn_q && op_b_q[WIDTH-1]) ? (~op_b_q + 1'b1) : op_b_q;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, bmag_q});
        rem_step = ge ? (shifted - {1'b0, bmag_q}) : shifted;
        quo_step = {quo_q[WIDTH-2:0], ge};
        quo_fix  = negq_q ? (~quo_step + 1'b1) : quo_step;
        rem_fix  = negr_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sgn_d     = sgn_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        bmag_d    = bmag_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_div = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_div = startE;
                if (startE && !cancel) begin
                    op_a_d  = srcaE;
                    op_b_d  = srcbE;
                    sgn_d   = signedE;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                stall_div = !cancel;
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    quo_d   = a_mag;
                    rem_d   = '0;
                    bmag_d  = b_mag;
                    negq_d  = sgn_q & (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
                    negr_d  = sgn_q & op_a_q[WIDTH-1];
                    dz_d    = (op_b_q == '0);
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef DIV_ZERO_FAST_EN
                    if (op_b_q == '0) begin
                        hi_d    = op_a_q;
                        lo_d    = '1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StRun: begin
                stall_div = !cancel;
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    // Results land in hi/lo on entry to DONE so they are valid with ready.
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                        if (dz_q) begin
                            hi_d = op_a_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign ready  = (state_q == StDone);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
